// File: rtl/servo_cmd_rx.sv
// UART 8N1 command receiver: turns framed {A5, HI, LO, CHK} packets into a clamped
// 16-bit servo angle, holding the last good value through noise or a lost link.
//
// bit receiver  | meaning
// B_IDLE        | line idle, waiting for rx_s low
// B_START       | half-bit wait, then confirm the start bit
// B_DATA        | sample 8 data bits, LSB first
// B_STOP        | sample the stop bit, emit byte_stb or stop_err
//
// frame parser  | meaning
// P_HUNT        | waiting for the 0xA5 header
// P_HI          | next byte is the angle high byte
// P_LO          | next byte is the angle low byte
// P_CHK         | next byte is the checksum
module servo_cmd_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int ANGLE_MAX    = 180,
  parameter int ANGLE_INIT   = 90,
  parameter int TIMEOUT_CLKS = 4 * 10 * (CLK_HZ / BAUD)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] angle_raw,
  output logic        angle_valid,
  output logic        err_chk,
  output logic        err_frame
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CPB_LD  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(TIMEOUT_CLKS);
  localparam logic [15:0]      A_MAX   = 16'(ANGLE_MAX);
  localparam logic [15:0]      A_INIT  = 16'(ANGLE_INIT);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {P_HUNT, P_HI, P_LO, P_CHK} frm_state_t;

  logic             rx_m, rx_s;
  bit_state_t       b_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_stb, stop_err;

  frm_state_t       p_state;
  logic [7:0]       hi_q, lo_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_m, rx_s} <= 2'b11;
    else     {rx_m, rx_s} <= {rx, rx_m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_state  <= B_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_stb <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      stop_err <= 1'b0;
      case (b_state)
        B_IDLE: begin
          if (!rx_s) begin
            b_state <= B_START;
            bit_cnt <= HALF_LD;
          end
        end
        B_START: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else if (rx_s) b_state <= B_IDLE;
          else begin
            b_state <= B_DATA;
            bit_cnt <= CPB_LD;
            bit_idx <= '0;
          end
        end
        B_DATA: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= CPB_LD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) b_state <= B_STOP;
          end
        end
        B_STOP: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          else begin
            b_state <= B_IDLE;
            if (rx_s) byte_stb <= 1'b1;
            else      stop_err <= 1'b1;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

  // An arriving byte always beats an expiring gap timer in the same cycle.
  assign timeout = (p_state != P_HUNT) && (gap_cnt == '0) && !byte_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state     <= P_HUNT;
      hi_q        <= '0;
      lo_q        <= '0;
      gap_cnt     <= '0;
      angle_raw   <= A_INIT;
      angle_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;

      if (byte_stb)               gap_cnt <= GAP_LD;
      else if (p_state == P_HUNT) gap_cnt <= '0;
      else if (gap_cnt != '0)     gap_cnt <= gap_cnt - 1'b1;

      if (stop_err) begin
        p_state   <= P_HUNT;
        err_frame <= 1'b1;
      end else if (byte_stb) begin
        case (p_state)
          P_HUNT: if (shreg == 8'hA5) p_state <= P_HI;
          P_HI: begin
            hi_q    <= shreg;
            p_state <= P_LO;
          end
          P_LO: begin
            lo_q    <= shreg;
            p_state <= P_CHK;
          end
          P_CHK: begin
            p_state <= P_HUNT;
            if (shreg == (hi_q ^ lo_q ^ 8'h5A)) begin
              angle_raw   <= ({hi_q, lo_q} > A_MAX) ? A_MAX : {hi_q, lo_q};
              angle_valid <= 1'b1;
            end else begin
              err_chk <= 1'b1;
            end
          end
          default: p_state <= P_HUNT;
        endcase
      end else if (timeout) begin
        p_state   <= P_HUNT;
        err_frame <= 1'b1;
      end
    end
  end

endmodule

// File: doc/servo_cmd_rx.md
# servo_cmd_rx

UART command receiver that sits directly upstream of the servo channel. It turns a serial command stream into the 16-bit `angle_raw` word that the servo stage low-pass filters and converts to PWM. An 8N1 receiver feeds a four-byte frame parser with a checksum. Only validated, clamped angles reach the output register; the servo therefore holds its last good position through line noise or a lost link.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate. `CPB = CLK_HZ/BAUD` (integer division); `HALF = CPB/2`.
- `ANGLE_MAX`, default 180: clamp ceiling for `angle_raw`.
- `ANGLE_INIT`, default 90: reset and power-on angle.
- `TIMEOUT_CLKS`, default 4*10*CPB: maximum allowed gap between bytes inside a frame.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rx`  in  1: UART line, idles high, asynchronous to `clk`.
- `angle_raw`  out  16: last accepted angle, held between updates.
- `angle_valid`  out  1: one-cycle pulse when `angle_raw` takes a new value.
- `err_chk`  out  1: one-cycle pulse on a checksum mismatch.
- `err_frame`  out  1: one-cycle pulse on a bad stop bit or an inter-byte timeout.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s` only.
- **Bit receiver FSM, IDLE → START:** leave IDLE on `rx_s` = 0.
- **START:** count `HALF` cycles, then sample.
  - Sample 1: return to IDLE as a glitch; no error is reported.
  - Sample 0: go to DATA.
- **DATA:** sample every `CPB` cycles, 8 bits, LSB first, shifted into the byte register.
- **STOP:** sample once after a further `CPB` cycles.
  - 1: emit internal `byte_stb` for one cycle.
  - 0: pulse `err_frame`, drop the byte, force the parser to HUNT.
  - Both cases return to IDLE, so a new start bit is accepted from the next cycle.
- **Frame format:** `0xA5`, `HI`, `LO`, `CHK`, where `CHK = HI ^ LO ^ 0x5A`.
- **Parser FSM:**
  - HUNT: a `byte_stb` carrying `0xA5` moves to GET_HI. Any other byte is silently ignored.
  - GET_HI: the byte is latched as HI, then GET_LO.
  - GET_LO: the byte is latched as LO, then GET_CHK.
  - GET_CHK: compare the byte against the checksum.
    - Match: accept the frame.
    - Mismatch: pulse `err_chk`, leave `angle_raw` unchanged.
    - Both cases return to HUNT.
  - `0xA5` arriving in GET_HI, GET_LO or GET_CHK is treated as data. There is no mid-frame resync.
- **Accept:** `v = {HI, LO}`.
  - `angle_raw <= (v > ANGLE_MAX) ? ANGLE_MAX : v`.
  - Pulse `angle_valid`.
- **Timeout:** a gap counter clears on every `byte_stb` and runs while the parser is not in HUNT.
  - On reaching `TIMEOUT_CLKS`: go to HUNT and pulse `err_frame`.
  - In HUNT the counter holds at 0.
- **Simultaneous events:**
  - Timeout and `byte_stb` in the same cycle: the byte wins and the counter clears.
  - Stop-bit error while the parser is mid-frame: `err_frame` pulses once, not twice.
- **Arithmetic:** the clamp is an unsigned 16-bit compare. `angle_raw` never exceeds `ANGLE_MAX`.

## Timing
- **Reset values:**
  - `angle_raw = ANGLE_INIT`.
  - `angle_valid`, `err_chk`, `err_frame` = 0.
  - Both FSMs in IDLE/HUNT, all counters 0.
  - Synchronizer flops reset to 1.
- **Bit sampling:** let t be the first cycle in which `rx_s` = 0.
  - Start sample at t+HALF.
  - Data bit i (0..7) at t+HALF+(i+1)·CPB.
  - Stop bit at t+HALF+9·CPB.
- **Latency:** `byte_stb` is high in the cycle after the stop sample. `angle_valid`, `err_chk` and the new `angle_raw` are registered in the cycle after the `byte_stb` for CHK. Total: rx edge to output is 2 sync cycles + HALF + 9·CPB + 2.
- **Output hold:** `angle_raw` changes only in the cycle `angle_valid` is high.
- **Reset mid-frame:** outputs return to reset values immediately and any partial byte or frame is discarded. A line that is still low when `rst` falls is taken as a start bit once `rx_s` shows it; if that byte then has a bad stop bit, `err_frame` pulses.
- **Back-to-back frames:** must be accepted with zero idle bits between stop and start.

## Test plan
Bench uses `CLK_HZ`=50 MHz, `BAUD`=115200, `CPB`=434.
1. Reset, no traffic → `angle_raw`=90; no pulses for 100 µs.
2. Bytes A5 00 2D 77 → one `angle_valid`, `angle_raw`=45, one clock after the CHK `byte_stb`.
3. A5 01 2C 77 (value 300) → `angle_raw`=180; A5 00 00 5A → `angle_raw`=0.
4. A5 00 2D 00 → `err_chk` pulse, `angle_raw` unchanged. A following valid 30° frame (A5 00 1E 44) → `angle_raw`=30.
5. Faults:
   - 1 µs low glitch on idle line → no pulses.
   - Byte with stop bit forced to 0 → one `err_frame`.
   - A5 00, then silence beyond `TIMEOUT_CLKS` → one `err_frame`, parser back in HUNT.
6. Reset asserted during the LO byte → outputs at reset values immediately. The next full frame after release is accepted normally.
